// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module : branch_predictor_pkg
// Brief  : Shared constants and counter encoding for the branch predictor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef RISCV_XLEN
`define RISCV_XLEN 32
`endif
`ifndef BP_IDX_W
`define BP_IDX_W 6
`endif
`ifndef BP_CTR_SNT
`define BP_CTR_SNT 2'b00
`define BP_CTR_WNT 2'b01
`define BP_CTR_WT  2'b10
`define BP_CTR_ST  2'b11
`endif

package branch_predictor_pkg;

  localparam int c_XLEN  = `RISCV_XLEN;
  localparam int c_IDX_W = `BP_IDX_W;

  typedef enum logic [1:0] {
    CTR_SNT = `BP_CTR_SNT,
    CTR_WNT = `BP_CTR_WNT,
    CTR_WT  = `BP_CTR_WT,
    CTR_ST  = `BP_CTR_ST
  } ctr_e;

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
// Module : bp_sat_counter
// Brief  : Combinational 2-bit saturating counter next-state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr_e'(ctr - 2'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module : branch_predictor
// Brief  : Direct-mapped BTB with 2-bit counters; 1-cycle lookup, EXU update.
//          Define BP_STATS_EN to add update/mispredict statistics counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN  = c_XLEN,
  parameter int IDX_W = c_IDX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int c_ENTRIES = 2 ** IDX_W;
  localparam int c_TAG_W   = XLEN - IDX_W - 2;

  logic               r_valid  [c_ENTRIES];
  logic [c_TAG_W-1:0] r_tag    [c_ENTRIES];
  logic [XLEN-1:0]    r_target [c_ENTRIES];
  ctr_e               r_ctr    [c_ENTRIES];

  logic [IDX_W-1:0]   w_req_idx;
  logic [c_TAG_W-1:0] w_req_tag;
  logic [1:0]         w_req_ctr;
  logic               w_req_hit;
  logic               w_req_taken;
  logic [XLEN-1:0]    w_req_target;

  logic [IDX_W-1:0]   w_upd_idx;
  logic [c_TAG_W-1:0] w_upd_tag;
  logic               w_upd_hit;
  logic               w_upd_mispredict;
  ctr_e               w_upd_ctr_next;

  // Word-alignment bits never participate in indexing or tagging.
  logic               w_unused_pc_bits;
  assign w_unused_pc_bits = ^{req_pc[1:0], upd_pc[1:0]};

  assign w_req_idx    = req_pc[IDX_W+1:2];
  assign w_req_tag    = req_pc[XLEN-1:IDX_W+2];
  assign w_req_ctr    = r_ctr[w_req_idx];
  assign w_req_hit    = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_req_taken  = w_req_hit && w_req_ctr[1];
  assign w_req_target = w_req_taken ? r_target[w_req_idx] : req_pc + XLEN'(4);

  assign w_upd_idx        = upd_pc[IDX_W+1:2];
  assign w_upd_tag        = upd_pc[XLEN-1:IDX_W+2];
  assign w_upd_hit        = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_mispredict = upd_valid && (upd_taken != upd_pred_taken);

  bp_sat_counter u_sat_counter (
    .ctr      (r_ctr[w_upd_idx]),
    .taken    (upd_taken),
    .ctr_next (w_upd_ctr_next)
  );

  // Lookup reads pre-update array contents: same-index update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      mispredict  <= 1'b0;
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_hit    <= w_req_hit;
        pred_taken  <= w_req_taken;
        pred_target <= w_req_target;
      end
      mispredict <= w_upd_mispredict;
      if (upd_valid) begin
        if (w_upd_hit) begin
          r_ctr[w_upd_idx] <= w_upd_ctr_next;
          if (upd_taken) r_target[w_upd_idx] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= upd_target;
          r_ctr[w_upd_idx]    <= CTR_WT;
        end
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else begin
      if (upd_valid)        stat_updates <= stat_updates + 32'd1;
      if (w_upd_mispredict) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Predicts conditional-branch outcomes at fetch.
- Is trained by the resolved outcome from the execute-stage branch comparator (the comparator's BrJp plus the computed target).
- Direct-mapped BTB with one 2-bit saturating counter per entry.
- Sits between IFU (lookup port) and EXU (update port); its prediction is later checked against the comparator's result.

Parameters:
- XLEN, 32, data/PC width; tied to `RISCV_XLEN.
- IDX_W, 6, index bits; ENTRIES = 2**IDX_W.
- TAG_W, XLEN-IDX_W-2, tag width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request this cycle.
- req_pc  in  XLEN  PC to predict.
- pred_valid  out  1  prediction valid; req_valid delayed one cycle.
- pred_hit  out  1  BTB tag hit.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  resolved conditional branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome (comparator BrJp).
- upd_target  in  XLEN  actual branch target.
- upd_pred_taken  in  1  prediction originally issued for this branch.
- mispredict  out  1  registered; upd_valid && (upd_taken != upd_pred_taken), one cycle after the update.

Behaviour:
- Address fields:
  - idx = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target, ctr[1:0].
- Counter encoding:
  - SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Taken increments, saturating at ST.
  - Not-taken decrements, saturating at SNT.
- Reset (async, rst_n low):
  - All valid bits=0, all ctr=WNT.
  - pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0, mispredict=0.
  - Targets and tags are don't-care; implementation may reset them to 0.
- Lookup timing (latency 1):
  - Array is read combinationally in cycle N; outputs are registered at edge N+1.
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : req_pc+4 (wraps modulo 2**XLEN).
- When req_valid=0, pred_valid=0 next cycle and the other pred_* outputs hold their previous values.
- Update (on clk edge when upd_valid=1):
  - Hit at upd idx: ctr updated by upd_taken. If upd_taken, target is overwritten with upd_target.
  - Miss and upd_taken: allocate. valid=1, tag=upd tag, target=upd_target, ctr=WT. Any existing entry at that index is replaced.
  - Miss and not taken: no state change.
- mispredict is registered at the same edge. It is 0 in any cycle following upd_valid=0.
- Simultaneous lookup and update to the same idx in the same cycle: the lookup sees pre-update state (no bypass).
- Back-to-back updates to the same idx apply sequentially, each edge using the previous edge's result.
- rst_n asserted mid-operation: state clears immediately. An in-flight pred_valid is dropped. The first prediction after reset deassertion is a miss with target req_pc+4.

Optional Feature:
- BP_STATS_EN defined:
  - Adds outputs stat_updates[31:0] and stat_mispred[31:0], reset to 0.
  - stat_updates increments on every upd_valid; stat_mispred increments on every update where upd_taken != upd_pred_taken.
  - Both wrap at 2**32.
- BP_STATS_EN undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared const.v header:
  - `BP_CTR_SNT/WNT/WT/ST encodings.
  - `BP_IDX_W default.
  - `RISCV_XLEN for the XLEN default.
- One sub-module, bp_sat_counter: combinational 2-bit saturating next-state (in: ctr, taken; out: ctr_next). It is instantiated on the update path only.

Test Plan:
- Reset, then lookup 0x80000000 -> next cycle pred_valid=1, hit=0, taken=0, target=0x80000004.
- Update pc=0x80000010, taken=1, target=0x80000100, pred_taken=0. Then lookup 0x80000010 -> hit=1, taken=1, target=0x80000100; mispredict=1 one cycle after the update.
- Same PC, update not-taken twice -> ctr WT->WNT->SNT. Lookup gives hit=1, taken=0, target=0x80000014. A third not-taken leaves ctr at SNT; then one taken -> WNT, still predicts not-taken.
- Saturation: four taken updates -> ctr=ST. One not-taken -> WT, lookup still predicts taken.
- Alias: 0x80000010 allocated, then taken update at 0x80001010 (same idx with IDX_W=6, different tag) -> lookup 0x80000010 misses, 0x80001010 hits with the new target.
- Same-cycle lookup and allocation at 0x80000020 -> that lookup misses, a lookup the following cycle hits. Assert rst_n while pred_valid=1 -> all outputs 0 immediately. With BP_STATS_EN, 5 updates with 2 mispredicts -> stat_updates=5, stat_mispred=2.
